// File: rtl/ps2_tx_if.sv
// Host-side command/status bundle for the PS/2 transmitter.
interface ps2_tx_if;
    logic [7:0] data;
    logic       send;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output data, send, input busy, done, error);
    modport slave  (input data, send, output busy, done, error);
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, start bit, 10 device-clocked bits, ACK check.
// Latency: ps2_clk_oe rises one cycle after send is accepted; bit pacing follows the device clock.
// Backpressure: send is accepted only while busy is low; requests during a transfer are dropped.
module ps2_tx #(
    parameter int FREQ       = 25000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic     clk,
    input  logic     rst_n,
    ps2_tx_if.slave  host,
    input  logic     ps2_clk_in,
    input  logic     ps2_data_in,
    output logic     ps2_clk_oe,
    output logic     ps2_data_oe
);
    localparam int INH_CYC = FREQ * INHIBIT_US / 1000;
    localparam int TO_CYC  = FREQ * TIMEOUT_US / 1000;
    localparam int TW      = ($clog2(TO_CYC + 1) > 19) ? $clog2(TO_CYC + 1) : 19;
    localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK_WAIT, LINE_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic          drive_bit_q, drive_bit_d;
    logic          error_q, error_d;
    logic          ack_q, ack_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [3:0]    clk_hist_q, clk_hist_d;
    logic          fall_edge;
    logic          timeout;
    logic          done_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            drive_bit_q <= 1'b0;
            error_q     <= 1'b0;
            ack_q       <= 1'b0;
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_hist_q  <= 4'b1111;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            drive_bit_q <= drive_bit_d;
            error_q     <= error_d;
            ack_q       <= ack_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_hist_q  <= clk_hist_d;
        end
    end

    // Oldest sample sits in bit 3; two highs followed by two lows is a clean falling edge.
    assign fall_edge = (clk_hist_q == 4'b1100);
    assign timeout   = (timer_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        drive_bit_d = drive_bit_q;
        error_d     = error_q;
        ack_d       = ack_q;
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d  = {dat_sync_q[0], ps2_data_in};
        clk_hist_d  = {clk_hist_q[2:0], clk_sync_q[1]};
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.send) begin
                    frame_d = {1'b1, ~^host.data, host.data};
                    error_d = 1'b0;
                    ack_d   = 1'b0;
                    timer_d = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer_q == INH_LAST) begin
                    state_d = START;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                timer_d     = '0;
                bit_cnt_d   = '0;
                drive_bit_d = 1'b1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = drive_bit_q & ~timeout;
                timer_d     = timer_q + TW'(1);
                if (timeout) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (fall_edge) begin
                    // Open-drain: drive low for a 0 bit, release for a 1 bit.
                    drive_bit_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK_WAIT;
                    end
                end
            end
            ACK_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (timeout) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (fall_edge) begin
                    ack_d   = ~dat_sync_q[1];
                    error_d = dat_sync_q[1];
                    state_d = LINE_IDLE;
                end
            end
            LINE_IDLE: begin
                timer_d = timer_q + TW'(1);
                if (timeout) begin
                    error_d = 1'b1;
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (clk_sync_q[1] && dat_sync_q[1]) begin
                    done_c  = ack_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign host.busy  = (state_q != IDLE);
    assign host.done  = done_c;
    assign host.error = error_q;
endmodule
